fp_reduce_tree_acc: RTL and testbench

- Parametrised successor to the fixed 16-input and 8-input single-precision adder trees.
- On a start pulse it captures NI IEEE-754 single-precision operands, which need not be a power of two.
- It reduces them level by level through a bank of shared adder_subtractor_with_start lanes (add mode), and reports the sum with a finish handshake.
- Adds an accumulate mode (result added to the previous summation), a busy flag and asynchronous reset; sits between the vector-product stage and the solver datapath.

---
 rtl/fp_reduce_tree_acc.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_reduce_tree_acc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_reduce_tree_acc.sv
// Parametrised IEEE-754 single-precision reduction tree with optional accumulate.
// Operands are reduced level by level through a shared bank of add lanes.

// One add/subtract lane: fixed ADD_LAT cycles from start to result; the
// result is held until the next one arrives.
module adder_subtractor_with_start #(
  parameter int ADD_LAT = 6
) (
  input  logic        clk,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        finish
);

  logic [31:0] res_p [ADD_LAT];
  logic        vld_p [ADD_LAT];

  // Round-to-nearest-even single-precision addition with IEEE specials.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic        sx, sy, sr;
    logic [9:0]  ex, ey, dd;
    logic [26:0] mx, my, my_al;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [31:0] res;
    res = '0;
    if (x[30:23] == 8'hFF && x[22:0] != '0)      res = x | 32'h0040_0000;
    else if (y[30:23] == 8'hFF && y[22:0] != '0) res = y | 32'h0040_0000;
    else if (x[30:23] == 8'hFF)
      res = (y[30:23] == 8'hFF && x[31] != y[31]) ? 32'h7FC0_0000 : x;
    else if (y[30:23] == 8'hFF)                   res = y;
    else if (x[30:0] == '0 && y[30:0] == '0)      res = {x[31] & y[31], 31'b0};
    else if (x[30:0] == '0)                       res = y;
    else if (y[30:0] == '0)                       res = x;
    else begin
      if (x[30:0] >= y[30:0]) begin
        sx = x[31]; sy = y[31];
        ex = (x[30:23] == 8'h00) ? 10'd1 : {2'b00, x[30:23]};
        ey = (y[30:23] == 8'h00) ? 10'd1 : {2'b00, y[30:23]};
        mx = {x[30:23] != 8'h00, x[22:0], 3'b000};
        my = {y[30:23] != 8'h00, y[22:0], 3'b000};
      end else begin
        sx = y[31]; sy = x[31];
        ex = (y[30:23] == 8'h00) ? 10'd1 : {2'b00, y[30:23]};
        ey = (x[30:23] == 8'h00) ? 10'd1 : {2'b00, x[30:23]};
        mx = {y[30:23] != 8'h00, y[22:0], 3'b000};
        my = {x[30:23] != 8'h00, x[22:0], 3'b000};
      end
      dd = ex - ey;
      if (dd > 10'd26) my_al = {26'b0, |my};
      else begin
        my_al = my >> dd;
        if ((my & ((27'd1 << dd) - 27'd1)) != '0) my_al[0] = 1'b1;
      end
      sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my_al}) : ({1'b0, mx} - {1'b0, my_al});
      sr = sx;
      if (sum == '0) res = 32'h0000_0000;
      else begin
        if (sum[27]) begin
          sum = {1'b0, sum[27:2], sum[1] | sum[0]};
          ex  = ex + 10'd1;
        end else begin
          for (int i = 0; i < 26; i++) begin
            if (!sum[26] && ex > 10'd1) begin
              sum = sum << 1;
              ex  = ex - 10'd1;
            end
          end
        end
        rnd = {1'b0, sum[26:3]} + ((sum[2] && (sum[1] | sum[0] | sum[3])) ? 25'd1 : 25'd0);
        if (rnd[24]) begin
          rnd = rnd >> 1;
          ex  = ex + 10'd1;
        end
        if (ex >= 10'd255)  res = {sr, 8'hFF, 23'b0};
        else if (!rnd[23])  res = {sr, 8'h00, rnd[22:0]};
        else                res = {sr, ex[7:0], rnd[22:0]};
      end
    end
    return res;
  endfunction

  // Result pipeline: compute on start, then walk the value down with its valid.
  always_ff @(posedge clk) begin
    vld_p[0] <= start;
    if (start) res_p[0] <= fp_add(a, {b[31] ^ sub, b[30:0]});
    for (int i = 1; i < ADD_LAT; i++) begin
      vld_p[i] <= vld_p[i-1];
      if (vld_p[i-1]) res_p[i] <= res_p[i-1];
    end
  end

  assign result = res_p[ADD_LAT-1];
  assign finish = vld_p[ADD_LAT-1];

endmodule

module fp_reduce_tree_acc #(
  parameter int NI      = 16,
  parameter int ADD_LAT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ExE_start,
  input  logic             acc_en,
  input  logic [NI*32-1:0] inputs,
  output logic [31:0]      summation,
  output logic             ExE_finish,
  output logic             ExE_finish_dash,
  output logic             busy
);

  localparam int LANES = (NI + 1) / 2;
  localparam int MW    = $clog2(NI + 1);
  localparam int LW    = $clog2(ADD_LAT + 2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, ACC_ISSUE, ACC_WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [31:0]      bank [NI];
  logic [31:0]      carry;
  logic [MW-1:0]    m, half, m_next;
  logic [LW-1:0]    lat_cnt;
  logic             acc_q;
  logic             accept;
  logic [31:0]      lane_a   [LANES];
  logic [31:0]      lane_b   [LANES];
  logic [31:0]      lane_res [LANES];
  logic [LANES-1:0] lane_start, lane_fin, fin_mask;

  assign half   = m >> 1;
  assign m_next = m - half;
  assign accept = (state == IDLE) && ExE_start && !ExE_finish;
  assign busy   = (state != IDLE) || ExE_finish;

  genvar j;
  generate
    for (j = 0; j < LANES; j++) begin : g_lane
      assign fin_mask[j] = (MW'(j) < half);
      assign lane_a[j]   = bank[2*j];
      if (j == 0) begin : g_first
        assign lane_b[j] = (state == ACC_ISSUE) ? summation : bank[1];
      end else if (2*j + 1 < NI) begin : g_pair
        assign lane_b[j] = bank[2*j+1];
      end else begin : g_odd
        assign lane_b[j] = '0;
      end
      adder_subtractor_with_start #(.ADD_LAT(ADD_LAT)) u_lane (
        .clk    (clk),
        .start  (lane_start[j]),
        .sub    (1'b0),
        .a      (lane_a[j]),
        .b      (lane_b[j]),
        .result (lane_res[j]),
        .finish (lane_fin[j])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and lane start pulses.
  always_comb begin
    state_nx   = state;
    lane_start = '0;
    case (state)
      IDLE:      if (accept) state_nx = ISSUE;
      ISSUE: begin
        lane_start = fin_mask;
        state_nx   = WAIT;
      end
      WAIT:      if (lat_cnt == LW'(ADD_LAT - 1)) state_nx = WB;
      WB: begin
        if (m_next > MW'(1)) state_nx = ISSUE;
        else if (acc_q)      state_nx = ACC_ISSUE;
        else                 state_nx = DONE;
      end
      ACC_ISSUE: begin
        lane_start[0] = 1'b1;
        state_nx      = ACC_WAIT;
      end
      ACC_WAIT:  if (lat_cnt == LW'(ADD_LAT)) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Operand bank, level bookkeeping and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) bank[k] <= '0;
      carry           <= '0;
      m               <= '0;
      lat_cnt         <= '0;
      acc_q           <= 1'b0;
      summation       <= '0;
      ExE_finish      <= 1'b0;
      ExE_finish_dash <= 1'b0;
    end else begin
      ExE_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = 0; k < NI; k++) bank[k] <= inputs[32*(NI-k)-1 -: 32];
            acc_q           <= acc_en;
            m               <= MW'(NI);
            ExE_finish_dash <= 1'b0;
          end
        end
        ISSUE: begin
          // An odd leftover operand skips this level untouched.
          for (int k = 0; k < NI; k++)
            if (m[0] && MW'(k) == m - MW'(1)) carry <= bank[k];
          lat_cnt <= '0;
        end
        WAIT:     lat_cnt <= lat_cnt + LW'(1);
        WB: begin
          for (int k = 0; k < LANES; k++)
            if (MW'(k) < half) bank[k] <= lane_res[k];
          for (int k = 0; k < NI; k++)
            if (m[0] && MW'(k) == half) bank[k] <= carry;
          m <= m_next;
        end
        ACC_ISSUE: lat_cnt <= '0;
        ACC_WAIT: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (lat_cnt == LW'(ADD_LAT)) bank[0] <= lane_res[0];
        end
        DONE: begin
          summation       <= bank[0];
          ExE_finish      <= 1'b1;
          ExE_finish_dash <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Lane finish pulses must line up with the counter-based completion.
  always @(posedge clk) begin
    if (!rst && state == WAIT && lat_cnt == LW'(ADD_LAT - 1))
      assert ((lane_fin & fin_mask) == fin_mask);
    if (!rst && state == ACC_WAIT && lat_cnt == LW'(ADD_LAT - 1))
      assert (lane_fin[0]);
  end

endmodule

// File: tb/tb_fp_reduce_tree_acc.sv
// Directed bench for fp_reduce_tree_acc: four instances (NI=16,5,3,2).
module tb_fp_reduce_tree_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic s16 = 0, a16 = 0, s5 = 0, a5 = 0, s3 = 0, a3 = 0, s2 = 0, a2 = 0;
  logic [511:0] in16 = '0;
  logic [159:0] in5  = '0;
  logic [95:0]  in3  = '0;
  logic [63:0]  in2  = '0;
  logic [31:0]  sum16, sum5, sum3, sum2;
  logic f16, d16, b16, f5, d5, b5, f3, d3, b3, f2, d2, b2;

  fp_reduce_tree_acc #(.NI(16)) u16 (.clk(clk), .rst(rst), .ExE_start(s16), .acc_en(a16),
    .inputs(in16), .summation(sum16), .ExE_finish(f16), .ExE_finish_dash(d16), .busy(b16));
  fp_reduce_tree_acc #(.NI(5)) u5 (.clk(clk), .rst(rst), .ExE_start(s5), .acc_en(a5),
    .inputs(in5), .summation(sum5), .ExE_finish(f5), .ExE_finish_dash(d5), .busy(b5));
  fp_reduce_tree_acc #(.NI(3)) u3 (.clk(clk), .rst(rst), .ExE_start(s3), .acc_en(a3),
    .inputs(in3), .summation(sum3), .ExE_finish(f3), .ExE_finish_dash(d3), .busy(b3));
  fp_reduce_tree_acc #(.NI(2)) u2 (.clk(clk), .rst(rst), .ExE_start(s2), .acc_en(a2),
    .inputs(in2), .summation(sum2), .ExE_finish(f2), .ExE_finish_dash(d2), .busy(b2));

  // 1.0 .. 16.0 in single precision
  logic [31:0] ints [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  int cyc = 0;
  int fc [4] = '{default: 0};
  int fa [4] = '{default: 0};
  int total = 0;
  int bad = 0;

  // Edge counter and finish-pulse log (count and edge index of the last pulse).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f16) begin fc[0] <= fc[0] + 1; fa[0] <= cyc + 1; end
    if (f5)  begin fc[1] <= fc[1] + 1; fa[1] <= cyc + 1; end
    if (f3)  begin fc[2] <= fc[2] + 1; fa[2] <= cyc + 1; end
    if (f2)  begin fc[3] <= fc[3] + 1; fa[3] <= cyc + 1; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fin(input int which, input int st, input string tag, output int lat);
    int prev;
    int n;
    prev = fc[which];
    n = 0;
    while (fc[which] == prev && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(fc[which] != prev), 32'd1);
    lat = fa[which] - st;
  endtask

  task automatic fill16(input logic [31:0] v);
    for (int k = 0; k < 16; k++) in16[32*(16-k)-1 -: 32] = v;
  endtask

  task automatic fill16_ints();
    for (int k = 0; k < 16; k++) in16[32*(16-k)-1 -: 32] = ints[k];
  endtask

  task automatic go16(input logic acc, output int st);
    @(negedge clk);
    s16 = 1'b1;
    a16 = acc;
    st  = cyc + 1;
    @(negedge clk);
    s16 = 1'b0;
    a16 = 1'b0;
  endtask

  initial begin
    int st;
    int lat;
    int c0;

    repeat (3) @(negedge clk);
    chk("rst_sum",  sum16, 32'h0);
    chk("rst_fin",  32'(f16), 32'd0);
    chk("rst_dash", 32'(d16), 32'd0);
    chk("rst_busy", 32'(b16), 32'd0);
    chk("rst_busy5", 32'(b5), 32'd0);
    rst = 1'b0;

    // 1.0 .. 16.0, plain reduction
    fill16_ints();
    go16(1'b0, st);
    chk("busy_run", 32'(b16), 32'd1);
    wait_fin(0, st, "t1", lat);
    chk("t1_lat", 32'(lat), 32'd34);
    chk("t1_sum", sum16, 32'h43080000);
    chk("t1_dash", 32'(d16), 32'd1);
    chk("t1_busy_after", 32'(b16), 32'd0);
    chk("t1_fin_pulse", 32'(f16), 32'd0);

    // all 1.0 then all 2.0 accumulated onto it
    fill16(32'h3F800000);
    go16(1'b0, st);
    wait_fin(0, st, "t2a", lat);
    chk("t2a_sum", sum16, 32'h41800000);
    chk("t2_dash_before", 32'(d16), 32'd1);
    fill16(32'h40000000);
    go16(1'b1, st);
    chk("t2_dash_after", 32'(d16), 32'd0);
    wait_fin(0, st, "t2b", lat);
    chk("t2b_lat", 32'(lat), 32'd42);
    chk("t2b_sum", sum16, 32'h42400000);

    // second start mid-operation must be ignored
    fill16_ints();
    c0 = fc[0];
    go16(1'b0, st);
    repeat (8) @(negedge clk);
    fill16(32'h41000000);
    s16 = 1'b1;
    a16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    a16 = 1'b0;
    wait_fin(0, st, "t3", lat);
    chk("t3_lat", 32'(lat), 32'd34);
    chk("t3_sum", sum16, 32'h43080000);
    repeat (60) @(negedge clk);
    chk("t3_pulses", 32'(fc[0] - c0), 32'd1);
    chk("t3_sum_hold", sum16, 32'h43080000);

    // reset during level-2 WAIT, then restart with all 0.5
    fill16_ints();
    go16(1'b0, st);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_sum", sum16, 32'h0);
    chk("t4_rst_busy", 32'(b16), 32'd0);
    chk("t4_rst_dash", 32'(d16), 32'd0);
    chk("t4_rst_fin", 32'(f16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c0 = fc[0];
    fill16(32'h3F000000);
    go16(1'b0, st);
    wait_fin(0, st, "t4", lat);
    chk("t4_lat", 32'(lat), 32'd34);
    chk("t4_sum", sum16, 32'h41000000);
    chk("t4_pulses", 32'(fc[0] - c0), 32'd1);

    // NI=5: 1..5, carries at two levels
    for (int k = 0; k < 5; k++) in5[32*(5-k)-1 -: 32] = ints[k];
    @(negedge clk);
    s5 = 1'b1;
    st = cyc + 1;
    @(negedge clk);
    s5 = 1'b0;
    wait_fin(1, st, "t5", lat);
    chk("t5_lat", 32'(lat), 32'd26);
    chk("t5_sum", sum5, 32'h41700000);

    // NI=3: +inf, 1.0, -0.0
    in3 = {32'h7F800000, 32'h3F800000, 32'h80000000};
    @(negedge clk);
    s3 = 1'b1;
    st = cyc + 1;
    @(negedge clk);
    s3 = 1'b0;
    wait_fin(2, st, "t6", lat);
    chk("t6_lat", 32'(lat), 32'd18);
    chk("t6_sum", sum3, 32'h7F800000);

    // NI=2: -0.0 + -0.0
    in2 = {32'h80000000, 32'h80000000};
    @(negedge clk);
    s2 = 1'b1;
    st = cyc + 1;
    @(negedge clk);
    s2 = 1'b0;
    wait_fin(3, st, "t7", lat);
    chk("t7_lat", 32'(lat), 32'd10);
    chk("t7_sum", sum2, 32'h80000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
